// File: rtl/burst_uploader.sv
// -----------------------------------------------------------------------------
// burst_uploader
// Writes a programmable-length burst of pattern words into a FIFO, then raises
// drain_en so the downstream FIFO-to-output path can empty it.
//
// Ports:
//   clk        block clock, rising edge
//   reset      asynchronous, active-low reset
//   start      one-cycle burst request, only honoured in IDLE
//   mode       pattern select latched at start (00 +STEP, 01 -STEP, 10 hold, 11 invert)
//   len        burst length latched at start (0 = empty burst)
//   abort      ends the burst at the next WAIT or NEXT state
//   fifo_busy  FIFO cannot take a write this cycle
//   fifo_full  FIFO full
//   fifo_we    write strobe, one cycle per word
//   fifo_din   word being written (the pattern register)
//   drain_en   downstream enable, set at burst end, cleared by the next start
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle pulse at burst end (normal or aborted)
//   count      words written in the current/last burst
//   value      pattern register (same as fifo_din)
// -----------------------------------------------------------------------------
module burst_uploader #(
  parameter int                 DATA_W = 8,
  parameter int                 LEN_W  = 10,
  parameter logic [DATA_W-1:0]  INIT   = DATA_W'(8'h41),
  parameter int                 STEP   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              fifo_busy,
  input  logic              fifo_full,
  output logic              fifo_we,
  output logic [DATA_W-1:0] fifo_din,
  output logic              drain_en,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count,
  output logic [DATA_W-1:0] value
);

  localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WRITE = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_r;
  state_t              nextState_s;
  logic [LEN_W-1:0]    lenLatch_r;
  logic [1:0]          modeLatch_r;
  logic [LEN_W-1:0]    count_r;
  logic [LEN_W-1:0]    countInc_s;
  logic [DATA_W-1:0]   value_r;
  logic                drainEn_r;

  // Pattern update applied once per written word; arithmetic wraps naturally.
  function automatic logic [DATA_W-1:0] nextPattern(input logic [1:0] m,
                                                    input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    case (m)
      2'b00:   r = v + STEP_V;
      2'b01:   r = v - STEP_V;
      2'b10:   r = v;
      2'b11:   r = ~v;
      default: r = v;
    endcase
    return r;
  endfunction

  // The burst can only end at count == len, so count never wraps mid-burst.
  assign countInc_s = count_r + LEN_W'(1);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state decode; abort is deliberately not looked at in WRITE so an
  // issued write always completes and gets counted.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (len == {LEN_W{1'b0}}) begin
            nextState_s = S_DONE;
          end else begin
            nextState_s = S_WAIT;
          end
        end else begin
          nextState_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (abort) begin
          nextState_s = S_DONE;
        end else if (!fifo_busy && !fifo_full) begin
          nextState_s = S_WRITE;
        end else begin
          nextState_s = S_WAIT;
        end
      end
      S_WRITE: nextState_s = S_NEXT;
      S_NEXT: begin
        if ((countInc_s == lenLatch_r) || abort) begin
          nextState_s = S_DONE;
        end else begin
          nextState_s = S_WAIT;
        end
      end
      S_DONE:  nextState_s = S_IDLE;
      default: nextState_s = S_IDLE;
    endcase
  end

  // Burst parameters, word counter, pattern register and drain enable.
  // The pattern register is only reset by reset, so bursts chain their values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lenLatch_r  <= {LEN_W{1'b0}};
      modeLatch_r <= 2'b00;
      count_r     <= {LEN_W{1'b0}};
      value_r     <= INIT;
      drainEn_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            lenLatch_r  <= len;
            modeLatch_r <= mode;
            count_r     <= {LEN_W{1'b0}};
            drainEn_r   <= 1'b0;
          end
        end
        S_NEXT: begin
          count_r <= countInc_s;
          value_r <= nextPattern(modeLatch_r, value_r);
        end
        S_DONE:  drainEn_r <= 1'b1;
        default: begin
        end
      endcase
    end
  end

  // Moore outputs decoded straight from the state register.
  assign fifo_we  = (state_r == S_WRITE);
  assign busy     = (state_r != S_IDLE);
  assign done     = (state_r == S_DONE);
  assign fifo_din = value_r;
  assign value    = value_r;
  assign count    = count_r;
  assign drain_en = drainEn_r;

endmodule

// File: doc/burst_uploader.md
# burst_uploader

Parametrised pattern generator that writes a programmable-length burst of data words into the FIFO, then hands off to the FIFO-to-output path by raising a drain enable. It sits between the push-button/control logic and the FIFO. It generalises the single-word "press to upload an incrementing byte" sequence to:
- configurable data width, burst length, start value and step;
- four pattern modes;
- flow control on FIFO busy/full;
- abort, done and word-count reporting.

## Interface
Parameters:
- DATA_W, 8, width of each FIFO word
- LEN_W, 10, width of burst length and word counter
- INIT, 8'h41, reset value of the pattern register (truncated or zero-extended to DATA_W)
- STEP, 1, increment/decrement amount (modulo 2^DATA_W)

Ports:
- clk  in  1  block clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE
- mode  in  2  pattern select, latched at start: 00 add STEP, 01 subtract STEP, 10 constant, 11 bitwise invert
- len  in  LEN_W  number of words in the burst, latched at start
- abort  in  1  stop the burst after any in-flight write completes
- fifo_busy  in  1  FIFO cannot accept a write this cycle
- fifo_full  in  1  FIFO full
- fifo_we  out  1  FIFO write strobe, one cycle per word
- fifo_din  out  DATA_W  word to write; equals the pattern register
- drain_en  out  1  enables the downstream FIFO-to-output path
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at burst end (normal or aborted)
- count  out  LEN_W  words written in the current/last burst
- value  out  DATA_W  current pattern register (same as fifo_din)

## Operation
- States: IDLE, WAIT, WRITE, NEXT, DONE. Outputs are Moore-decoded from the state register: fifo_we = (state==WRITE), busy = (state!=IDLE), done = (state==DONE).
- **IDLE**:
  - On start, latch len and mode, clear count to 0 and clear drain_en.
  - If len==0, go to DONE; otherwise go to WAIT.
  - abort is ignored in IDLE.
- **WAIT**:
  - If abort, go to DONE.
  - Else if !fifo_busy and !fifo_full, go to WRITE.
  - Else stay in WAIT, with no timeout.
- **WRITE**: go to NEXT unconditionally. abort is not sampled here, so the write always completes.
- **NEXT**:
  - count += 1.
  - Update the pattern register by the latched mode: 00 adds STEP, 01 subtracts STEP, 10 holds, 11 inverts. Arithmetic wraps modulo 2^DATA_W.
  - If the new count equals the latched len, or abort is high, go to DONE; otherwise go to WAIT.
- **DONE**: set drain_en=1 and go to IDLE. drain_en stays high until the next accepted start.
- The pattern register is not reset between bursts. The next burst continues from the last value.
- start while busy is ignored and is not queued.
- Changes to len/mode while busy have no effect.

## Timing
- Reset (asynchronous, on reset low) sets:
  - state=IDLE
  - fifo_we=0, busy=0, done=0, drain_en=0
  - count=0
  - value=fifo_din=INIT
- start is sampled at edge E0, giving WAIT in the next cycle.
- With the FIFO free, fifo_we is high in the cycle after edge E1.
- Each word takes 3 cycles when the FIFO is free: WAIT, WRITE, NEXT.
- A burst of N≥1 words with no stalls:
  - done is high during the cycle following edge E(3N);
  - drain_en rises one edge later;
  - busy falls at that same edge.
- len==0: done is high in the cycle after E0, and no fifo_we is issued.
- fifo_din is stable from WAIT entry through the WRITE cycle. It changes only at the NEXT→ edge.
- A stall (fifo_busy or fifo_full) extends WAIT cycle-for-cycle. fifo_we is never asserted while either flag was high at the preceding edge.
- Aborted burst: count reports the words actually written. done still pulses once.
- count at len=2^LEN_W−1 does not wrap mid-burst.

## Test plan
- Reset release, INIT=8'h41, start, len=3, mode=00, FIFO free -> three fifo_we pulses with din 41, 42, 43, spaced 3 cycles apart; done pulses once; count=3; value=44; drain_en=1.
- A second start with len=2, mode=01 -> din 44, 43; drain_en drops at start and returns after done; value=42.
- Mode=11, len=4 from value 8'h0F -> din 0F, F0, 0F, F0. Mode=10, len=3 -> din repeated 3 times. DATA_W=8 wrap: from 8'hFF with mode=00 -> next word is 00.
- fifo_full held high for 5 cycles inside a len=2 burst -> no fifo_we while full; the first write occurs 2 cycles after full drops; total words 2.
- abort asserted in the WRITE cycle of word 2 of len=5 -> word 2 is written; done follows; count=2; no further fifo_we. len=0 start -> done with no writes, count=0.
- reset driven low mid-burst (in WRITE) -> fifo_we, busy and drain_en drop immediately; value=INIT, count=0; start while busy is ignored, and a start after reset runs normally.
